// File: rtl/stream_keystream_encryptor.sv
// Stream-cipher byte encryptor: a keyed Galois LFSR yields one keystream byte per 8 steps,
// which is XORed with the input byte. Optional STREAM_ENC_BYPASS_EN adds a per-byte bypass input.
module stream_keystream_encryptor #(
  parameter int unsigned       LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_W-1:0] RESET_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [LFSR_W-1:0] key_in,
  input  logic              key_load,
  input  logic [7:0]        data_in,
  input  logic              data_in_valid,
`ifdef STREAM_ENC_BYPASS_EN
  input  logic              bypass,
`endif
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        data_out,
  output logic              data_out_pulse
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        dbuf_q, dbuf_d;
  logic [7:0]        ks_q, ks_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              pulse_q, pulse_d;
  logic              overrun_q, overrun_d;
  logic              byp_active;
  logic              out_bit;
  logic              step_bit;
  logic [LFSR_W-1:0] lfsr_next;

`ifdef STREAM_ENC_BYPASS_EN
  logic byp_q, byp_d;
  assign byp_active = byp_q;
`else
  assign byp_active = 1'b0;
`endif

  assign out_bit   = lfsr_q[0];
  // In bypass the byte still takes 8 steps, but contributes zero keystream.
  assign step_bit  = byp_active ? 1'b0 : out_bit;
  assign lfsr_next = (lfsr_q >> 1) ^ (out_bit ? TAPS : '0);

  // NOTE: every variable gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    dbuf_d     = dbuf_q;
    ks_d       = ks_q;
    data_out_d = data_out_q;
    pulse_d    = 1'b0;
    overrun_d  = overrun_q;
`ifdef STREAM_ENC_BYPASS_EN
    byp_d      = byp_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (key_load) begin
          // An all-zero seed would lock the LFSR at zero forever.
          lfsr_d    = (key_in == '0) ? LFSR_W'(1) : key_in;
          overrun_d = data_in_valid;
        end else if (data_in_valid) begin
          dbuf_d  = data_in;
          cnt_d   = 3'd0;
          state_d = SHIFT;
`ifdef STREAM_ENC_BYPASS_EN
          byp_d   = bypass;
`endif
        end
      end
      SHIFT: begin
        if (data_in_valid) overrun_d = 1'b1;
        if (!byp_active) lfsr_d = lfsr_next;
        ks_d  = {ks_q[6:0], step_bit};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          data_out_d = dbuf_q ^ {ks_q[6:0], step_bit};
          pulse_d    = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      lfsr_q     <= RESET_SEED;
      cnt_q      <= 3'd0;
      dbuf_q     <= 8'h00;
      ks_q       <= 8'h00;
      data_out_q <= 8'h00;
      pulse_q    <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef STREAM_ENC_BYPASS_EN
      byp_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      dbuf_q     <= dbuf_d;
      ks_q       <= ks_d;
      data_out_q <= data_out_d;
      pulse_q    <= pulse_d;
      overrun_q  <= overrun_d;
`ifdef STREAM_ENC_BYPASS_EN
      byp_q      <= byp_d;
`endif
    end
  end

  assign busy           = (state_q == SHIFT);
  assign overrun        = overrun_q;
  assign data_out       = data_out_q;
  assign data_out_pulse = pulse_q;

endmodule

// File: tb/tb_stream_keystream_encryptor.sv
// Directed bench for stream_keystream_encryptor; expected bytes are hand-derived from the
// TAPS=16'hB400 Galois LFSR. Bypass scenario is built only with STREAM_ENC_BYPASS_EN.
module tb_stream_keystream_encryptor;

  logic        clk = 1'b0;
  logic        nrst;
  logic [15:0] key_in;
  logic        key_load;
  logic [7:0]  data_in;
  logic        data_in_valid;
`ifdef STREAM_ENC_BYPASS_EN
  logic        bypass;
`endif
  logic        busy;
  logic        overrun;
  logic [7:0]  data_out;
  logic        data_out_pulse;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_keystream_encryptor dut (
    .clk           (clk),
    .nrst          (nrst),
    .key_in        (key_in),
    .key_load      (key_load),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
`ifdef STREAM_ENC_BYPASS_EN
    .bypass        (bypass),
`endif
    .busy          (busy),
    .overrun       (overrun),
    .data_out      (data_out),
    .data_out_pulse(data_out_pulse)
  );

  task automatic load_key(input logic [15:0] k);
    @(negedge clk);
    key_in   = k;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  // Issues one byte, then measures latency, busy width, result and pulse width.
  task automatic run_byte(input string name, input logic [7:0] din, input logic [7:0] exp);
    int lat;
    int busy_cnt;
    @(negedge clk);
    data_in       = din;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!data_out_pulse && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL %s latency: got %0d want 8", name, lat);
    end
    checks++;
    if (busy_cnt !== 8 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy: high %0d cycles, busy at pulse %b; want 8 and 0", name, busy_cnt, busy);
    end
    checks++;
    if (data_out !== exp) begin
      failures++;
      $display("FAIL %s data_out: got %h want %h", name, data_out, exp);
    end
    @(negedge clk);
    checks++;
    if (data_out_pulse !== 1'b0 || data_out !== exp) begin
      failures++;
      $display("FAIL %s pulse width/hold: pulse %b data %h want 0 and %h", name, data_out_pulse, data_out, exp);
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0; key_in = '0; key_load = 1'b0; data_in = '0; data_in_valid = 1'b0;
`ifdef STREAM_ENC_BYPASS_EN
    bypass = 1'b0;
`endif
    #12;
    checks++;
    if ({busy, overrun, data_out, data_out_pulse} !== 11'd0 || dut.lfsr_q !== 16'hACE1) begin
      failures++;
      $display("FAIL reset_state: busy %b ovr %b dout %h pulse %b lfsr %h want 0 0 00 0 ace1",
               busy, overrun, data_out, data_out_pulse, dut.lfsr_q);
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_basic;
    load_key(16'h0001);
    run_byte("key0001_byte00", 8'h00, 8'h80);
    checks++;
    if (dut.lfsr_q !== 16'h0168) begin
      failures++;
      $display("FAIL lfsr_after_byte: got %h want 0168", dut.lfsr_q);
    end
  endtask

  // Keystream persists: the next byte continues from lfsr=0168.
  task automatic test_back_to_back;
    run_byte("continue_byte00", 8'h00, 8'h16);
  endtask

  task automatic test_zero_key;
    load_key(16'h0000);
    run_byte("zero_key_byte00", 8'h00, 8'h80);
  endtask

  task automatic test_roundtrip;
    load_key(16'h1234);
    run_byte("encrypt_5a", 8'h5A, 8'h76);
    load_key(16'h1234);
    run_byte("decrypt_76", 8'h76, 8'h5A);
  endtask

  task automatic test_overrun;
    int pulses;
    load_key(16'h0001);
    @(negedge clk);
    data_in = 8'h00; data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    data_in = 8'hFF; data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (data_out_pulse) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 1 || data_out !== 8'h80) begin
      failures++;
      $display("FAIL overrun_drop: pulses %0d data %h want 1 and 80", pulses, data_out);
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    load_key(16'h0001);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear: got %b want 0", overrun);
    end
  endtask

  // key_load and data_in_valid together: key wins, byte dropped, overrun set.
  task automatic test_load_collision;
    @(negedge clk);
    key_in = 16'h0001; key_load = 1'b1;
    data_in = 8'h55; data_in_valid = 1'b1;
    @(negedge clk);
    key_load = 1'b0; data_in_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL collision: overrun %b busy %b want 1 0", overrun, busy);
    end
    run_byte("after_collision", 8'h00, 8'h80);
  endtask

  task automatic test_reset_mid_shift;
    int pulses;
    load_key(16'h0001);
    @(negedge clk);
    data_in = 8'h00; data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    @(negedge clk);
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    @(negedge clk);
    #1 nrst = 1'b0;
    #1;
    checks++;
    if ({busy, overrun, data_out, data_out_pulse} !== 11'd0) begin
      failures++;
      $display("FAIL reset_mid_shift outputs: busy %b ovr %b dout %h pulse %b want all 0",
               busy, overrun, data_out, data_out_pulse);
    end
    @(negedge clk);
    nrst = 1'b1;
    checks++;
    if (dut.lfsr_q !== 16'hACE1) begin
      failures++;
      $display("FAIL reset_mid_shift lfsr: got %h want ace1", dut.lfsr_q);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (data_out_pulse || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL reset_mid_shift no_pulse: %0d active cycles want 0", pulses);
    end
  endtask

`ifdef STREAM_ENC_BYPASS_EN
  task automatic test_bypass;
    load_key(16'h0001);
    bypass = 1'b1;
    run_byte("bypass_c3", 8'hC3, 8'hC3);
    bypass = 1'b0;
    run_byte("after_bypass", 8'h00, 8'h80);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_key();
    test_roundtrip();
    test_overrun();
    test_load_collision();
    test_reset_mid_shift();
`ifdef STREAM_ENC_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
